// File: rtl/ctrl_seq.sv
// Sequenced control unit for the 9-bit accumulator ISA: decode, run/stall/done FSM,
// data-memory load stall and a saturating retired-instruction counter.
package ctrl_seq_pkg;
  typedef enum logic [3:0] {NOP, ADD, SUB, AND, XOR, LSH, RXOR, CLB} op_mne;
endpackage

module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int W        = 8,
  parameter int T        = 10,
  parameter int MEM_LAT  = 1,
  parameter int LINK_REG = 14,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instruction,
  input  logic [W-1:0]     ALU_Out,
  input  logic [W-1:0]     RegOutA,
  input  logic [W-1:0]     RegOutB,
  input  logic [T-1:0]     ProgCtr_p1,
  input  logic [W-1:0]     mem_out,
  output op_mne            ALU_OP,
  output logic [W-1:0]     ALU_A,
  output logic [W-1:0]     ALU_B,
  output logic [3:0]       RaddrA,
  output logic [3:0]       RaddrB,
  output logic [3:0]       Waddr,
  output logic [W-1:0]     RegInput,
  output logic             RegWrite,
  output logic             write_mem,
  output logic             PC_en,
  output logic             BranchTaken,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [3:0]        ldw_reg_q, ldw_reg_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              retire;

  logic [3:0] opcode;
  logic [3:0] operand;
  logic       wait_last;

  assign opcode    = Instruction[7:4];
  assign operand   = Instruction[3:0];
  assign wait_last = (wait_q <= 4'd1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      ldw_reg_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ldw_reg_q <= ldw_reg_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ldw_reg_d = ldw_reg_q;
    unique case (state_q)
      S_IDLE: if (Start) state_d = S_RUN;
      S_RUN: begin
        if (!Instruction[8]) begin
          if (opcode == 4'h2 && MEM_LAT != 0) begin
            state_d   = S_MEM_WAIT;
            wait_d    = 4'(MEM_LAT);
            ldw_reg_d = operand;
          end else if (opcode == 4'hB) begin
            state_d = S_DONE;
          end
        end
      end
      S_MEM_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_last) state_d = S_RUN;
      end
      S_DONE: if (!Start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALU_OP      = NOP;
    ALU_A       = RegOutA;
    ALU_B       = RegOutB;
    RegInput    = ALU_Out;
    RaddrA      = '0;
    RaddrB      = '0;
    Waddr       = '0;
    RegWrite    = 1'b0;
    write_mem   = 1'b0;
    PC_en       = 1'b0;
    BranchTaken = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        PC_en    = 1'b1;
        RegWrite = 1'b1;
        if (Instruction[8]) begin
          ALU_A = W'(Instruction[7:0]);
        end else begin
          case (opcode)
            4'h0: Waddr = operand;
            4'h1: RaddrA = operand;
            4'h2: begin
              RaddrA   = operand;
              RegInput = mem_out;
              if (MEM_LAT != 0) begin
                RegWrite = 1'b0;
                PC_en    = 1'b0;
              end
            end
            4'h3: begin
              RaddrA    = operand;
              RegWrite  = 1'b0;
              write_mem = 1'b1;
            end
            4'h4: begin
              RaddrA = operand;
              Waddr  = operand;
              if (operand >= 4'd8 && operand <= 4'd10) begin
                ALU_OP = SUB;
                ALU_B  = W'(1);
              end else if (operand >= 4'd11 && operand <= 4'd13) begin
                ALU_OP = ADD;
                ALU_B  = W'(1);
              end
            end
            4'h5: begin
              ALU_OP = CLB;
              RaddrA = operand;
              Waddr  = operand;
            end
            4'h6: begin ALU_OP = ADD;  RaddrA = operand; end
            4'h7: begin ALU_OP = AND;  RaddrA = operand; end
            4'h8: begin ALU_OP = LSH;  ALU_A = W'(Instruction[2:0]); end
            4'h9: begin ALU_OP = RXOR; RaddrA = operand; end
            4'hA: begin ALU_OP = XOR;  RaddrA = operand; end
            // DNE retires even though the PC is frozen from here on.
            4'hB: begin
              RegWrite = 1'b0;
              PC_en    = 1'b0;
              retire   = 1'b1;
            end
            4'hC: begin RegWrite = 1'b0; RaddrA = operand; BranchTaken = (RegOutA != '0); end
            4'hD: begin RegWrite = 1'b0; RaddrA = operand; BranchTaken = (RegOutA == '0); end
            4'hE: begin RegWrite = 1'b0; RaddrA = operand; BranchTaken = 1'b1; end
            4'hF: begin
              RaddrA      = operand;
              Waddr       = 4'(LINK_REG);
              RegInput    = W'(ProgCtr_p1);
              BranchTaken = 1'b1;
            end
          endcase
        end
      end
      S_MEM_WAIT: begin
        RaddrA   = ldw_reg_q;
        RegInput = mem_out;
        if (wait_last) begin
          RegWrite = 1'b1;
          PC_en    = 1'b1;
        end
      end
      default: ;
    endcase
    retire = retire | PC_en;
  end

  always_comb begin
    done_d  = (state_d == S_DONE);
    count_d = count_q;
    if (retire && count_q != '1) count_d = count_q + CNT_W'(1);
  end

  assign Busy       = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
  assign Done       = done_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: three instances (MEM_LAT=3, MEM_LAT=0, CNT_W=4) share stimulus;
// expectations are queued per cycle and drained against the outputs at the falling edge.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic       Clk, Reset, Start;
  logic [8:0] Instruction;
  logic [7:0] ALU_Out, RegOutA, RegOutB, mem_out;
  logic [9:0] ProgCtr_p1;

  op_mne       m_op;   logic [7:0] m_a, m_b, m_rin;  logic [3:0] m_ra, m_rb, m_wa;
  logic        m_rw, m_wm, m_pc, m_br, m_busy, m_done; logic [15:0] m_cnt;
  op_mne       z_op;   logic [7:0] z_a, z_b, z_rin;  logic [3:0] z_ra, z_rb, z_wa;
  logic        z_rw, z_wm, z_pc, z_br, z_busy, z_done; logic [15:0] z_cnt;
  op_mne       c_op;   logic [7:0] c_a, c_b, c_rin;  logic [3:0] c_ra, c_rb, c_wa;
  logic        c_rw, c_wm, c_pc, c_br, c_busy, c_done; logic [3:0] c_cnt;

  ctrl_seq #(.W(8), .T(10), .MEM_LAT(3), .LINK_REG(14), .CNT_W(16)) u_main (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .ALU_Out(ALU_Out),
    .RegOutA(RegOutA), .RegOutB(RegOutB), .ProgCtr_p1(ProgCtr_p1), .mem_out(mem_out),
    .ALU_OP(m_op), .ALU_A(m_a), .ALU_B(m_b), .RaddrA(m_ra), .RaddrB(m_rb), .Waddr(m_wa),
    .RegInput(m_rin), .RegWrite(m_rw), .write_mem(m_wm), .PC_en(m_pc), .BranchTaken(m_br),
    .Busy(m_busy), .Done(m_done), .InstrCount(m_cnt));

  ctrl_seq #(.W(8), .T(10), .MEM_LAT(0), .LINK_REG(14), .CNT_W(16)) u_lat0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .ALU_Out(ALU_Out),
    .RegOutA(RegOutA), .RegOutB(RegOutB), .ProgCtr_p1(ProgCtr_p1), .mem_out(mem_out),
    .ALU_OP(z_op), .ALU_A(z_a), .ALU_B(z_b), .RaddrA(z_ra), .RaddrB(z_rb), .Waddr(z_wa),
    .RegInput(z_rin), .RegWrite(z_rw), .write_mem(z_wm), .PC_en(z_pc), .BranchTaken(z_br),
    .Busy(z_busy), .Done(z_done), .InstrCount(z_cnt));

  ctrl_seq #(.W(8), .T(10), .MEM_LAT(1), .LINK_REG(14), .CNT_W(4)) u_cnt4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .ALU_Out(ALU_Out),
    .RegOutA(RegOutA), .RegOutB(RegOutB), .ProgCtr_p1(ProgCtr_p1), .mem_out(mem_out),
    .ALU_OP(c_op), .ALU_A(c_a), .ALU_B(c_b), .RaddrA(c_ra), .RaddrB(c_rb), .Waddr(c_wa),
    .RegInput(c_rin), .RegWrite(c_rw), .write_mem(c_wm), .PC_en(c_pc), .BranchTaken(c_br),
    .Busy(c_busy), .Done(c_done), .InstrCount(c_cnt));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef enum {S_ALUOP, S_ALUA, S_ALUB, S_WADDR, S_RADDRA, S_RADDRB, S_REGIN, S_RW, S_WM,
                S_PCEN, S_BR, S_BUSY, S_DONE, S_CNT, S_Z_RW, S_Z_PCEN, S_Z_REGIN, S_C_CNT} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic ex(input string name, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_ALUOP:   return 32'(m_op);
      S_ALUA:    return 32'(m_a);
      S_ALUB:    return 32'(m_b);
      S_WADDR:   return 32'(m_wa);
      S_RADDRA:  return 32'(m_ra);
      S_RADDRB:  return 32'(m_rb);
      S_REGIN:   return 32'(m_rin);
      S_RW:      return 32'(m_rw);
      S_WM:      return 32'(m_wm);
      S_PCEN:    return 32'(m_pc);
      S_BR:      return 32'(m_br);
      S_BUSY:    return 32'(m_busy);
      S_DONE:    return 32'(m_done);
      S_CNT:     return 32'(m_cnt);
      S_Z_RW:    return 32'(z_rw);
      S_Z_PCEN:  return 32'(z_pc);
      S_Z_REGIN: return 32'(z_rin);
      S_C_CNT:   return 32'(c_cnt);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // One clock: the DUT settles, queued expectations for this cycle are checked, then the edge.
  task automatic tick();
    exp_t        e;
    logic [31:0] obs;
    @(negedge Clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    ALU_Out = 8'h33;
    ex("rst_busy", S_BUSY, 0);  ex("rst_done", S_DONE, 0);  ex("rst_cnt", S_CNT, 0);
    ex("rst_rw", S_RW, 0);      ex("rst_pcen", S_PCEN, 0);  ex("rst_op", S_ALUOP, NOP);
    ex("rst_waddr", S_WADDR, 0); ex("rst_raddrb", S_RADDRB, 0);
    ex("rst_alub", S_ALUB, 8'h5A); ex("rst_regin", S_REGIN, 8'h33);
    ex("rst_c_cnt", S_C_CNT, 0);
    tick();
    $display("test_reset done");
  endtask

  task automatic test_immediate();
    do_reset();
    Start = 1'b1;
    Instruction = 9'h13C;
    ex("imm_idle_pcen", S_PCEN, 0);
    tick();
    ex("imm_alua", S_ALUA, 8'h3C); ex("imm_waddr", S_WADDR, 0); ex("imm_rw", S_RW, 1);
    ex("imm_pcen", S_PCEN, 1);     ex("imm_busy", S_BUSY, 1);   ex("imm_cnt0", S_CNT, 0);
    tick();
    ex("imm_cnt1", S_CNT, 1);
    tick();
    $display("test_immediate done");
  endtask

  task automatic test_ldw();
    do_reset();
    Start = 1'b1;
    Instruction = 9'h025;
    mem_out = 8'hA7;
    tick();
    ex("ldw_issue_rw", S_RW, 0); ex("ldw_issue_pcen", S_PCEN, 0); ex("ldw_issue_ra", S_RADDRA, 5);
    ex("ldw0_rw", S_Z_RW, 1);    ex("ldw0_pcen", S_Z_PCEN, 1);    ex("ldw0_regin", S_Z_REGIN, 8'hA7);
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) Start = 1'b0;
      ex($sformatf("ldw_w%0d_ra", i), S_RADDRA, 5);
      ex($sformatf("ldw_w%0d_busy", i), S_BUSY, 1);
      ex($sformatf("ldw_w%0d_rw", i), S_RW, (i == 3) ? 1 : 0);
      ex($sformatf("ldw_w%0d_pcen", i), S_PCEN, (i == 3) ? 1 : 0);
      if (i == 3) begin
        ex("ldw_regin", S_REGIN, 8'hA7);
        ex("ldw_waddr", S_WADDR, 0);
        ex("ldw_cnt_before", S_CNT, 0);
      end
      tick();
    end
    Instruction = 9'h13C;
    ex("ldw_cnt_after", S_CNT, 1); ex("ldw_back_run", S_RW, 1); ex("ldw_busy_after", S_BUSY, 1);
    tick();
    $display("test_ldw done");
  endtask

  task automatic test_branch();
    do_reset();
    Start = 1'b1;
    Instruction = 9'h0C2;
    RegOutA = 8'h00;
    tick();
    ex("jnz0_br", S_BR, 0); ex("jnz0_pcen", S_PCEN, 1); ex("jnz0_rw", S_RW, 0); ex("jnz0_ra", S_RADDRA, 2);
    tick();
    RegOutA = 8'h01;
    ex("jnz1_br", S_BR, 1); ex("jnz1_pcen", S_PCEN, 1);
    tick();
    Instruction = 9'h0D2;
    RegOutA = 8'h00;
    ex("jez0_br", S_BR, 1);
    tick();
    RegOutA = 8'h80;
    ex("jez1_br", S_BR, 0);
    tick();
    Instruction = 9'h0E0;
    ex("jmp_br", S_BR, 1); ex("jmp_rw", S_RW, 0);
    tick();
    Instruction = 9'h0F3;
    ProgCtr_p1 = 10'h045;
    ex("jal_waddr", S_WADDR, 14); ex("jal_regin", S_REGIN, 8'h45); ex("jal_rw", S_RW, 1);
    ex("jal_br", S_BR, 1);        ex("jal_ra", S_RADDRA, 3);       ex("jal_pcen", S_PCEN, 1);
    tick();
    $display("test_branch done");
  endtask

  task automatic test_decode();
    logic [8:0] ins [12] = '{9'h049, 9'h04C, 9'h044, 9'h067, 9'h077, 9'h0A1,
                             9'h093, 9'h05B, 9'h036, 9'h01A, 9'h00D, 9'h085};
    op_mne      ops [12] = '{SUB, ADD, NOP, ADD, AND, XOR, RXOR, CLB, NOP, NOP, NOP, LSH};
    logic [7:0] alub[12] = '{8'h01, 8'h01, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
                             8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    logic [3:0] wa  [12] = '{4'h9, 4'hC, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 4'hD, 4'h0};
    logic [3:0] ra  [12] = '{4'h9, 4'hC, 4'h4, 4'h7, 4'h7, 4'h1, 4'h3, 4'hB, 4'h6, 4'hA, 4'h0, 4'h0};
    logic       rw  [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    logic       wm  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    do_reset();
    Start = 1'b1;
    RegOutA = 8'h77;
    RegOutB = 8'h5A;
    Instruction = ins[0];
    tick();
    for (int k = 0; k < 12; k++) begin
      Instruction = ins[k];
      ex($sformatf("dec_%03h_op", ins[k]), S_ALUOP, 32'(ops[k]));
      ex($sformatf("dec_%03h_alub", ins[k]), S_ALUB, 32'(alub[k]));
      ex($sformatf("dec_%03h_waddr", ins[k]), S_WADDR, 32'(wa[k]));
      ex($sformatf("dec_%03h_raddra", ins[k]), S_RADDRA, 32'(ra[k]));
      ex($sformatf("dec_%03h_rw", ins[k]), S_RW, 32'(rw[k]));
      ex($sformatf("dec_%03h_wm", ins[k]), S_WM, 32'(wm[k]));
      ex($sformatf("dec_%03h_alua", ins[k]), S_ALUA, (ins[k] == 9'h085) ? 32'h5 : 32'h77);
      tick();
    end
    $display("test_decode done");
  endtask

  task automatic test_done();
    do_reset();
    Start = 1'b1;
    Instruction = 9'h13C;
    tick();
    ex("dne_pre_pcen", S_PCEN, 1);
    tick();
    Instruction = 9'h0B0;
    ex("dne_rw", S_RW, 0); ex("dne_pcen", S_PCEN, 0); ex("dne_busy", S_BUSY, 1); ex("dne_done0", S_DONE, 0);
    tick();
    ex("done_done", S_DONE, 1); ex("done_busy", S_BUSY, 0); ex("done_cnt", S_CNT, 2); ex("done_pcen", S_PCEN, 0);
    tick();
    ex("done_hold", S_DONE, 1);
    tick();
    Start = 1'b0;
    ex("done_release", S_DONE, 1);
    tick();
    ex("idle_done", S_DONE, 0); ex("idle_busy", S_BUSY, 0);
    tick();
    $display("test_done done");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    Start = 1'b1;
    Instruction = 9'h13C;
    tick();
    tick();
    Instruction = 9'h025;
    tick();
    tick();
    Reset = 1'b1;
    Start = 1'b1;
    ex("rw_mw2_cnt", S_CNT, 1); ex("rw_mw2_busy", S_BUSY, 1); ex("rw_mw2_rw", S_RW, 0);
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    ex("rw_after_busy", S_BUSY, 0); ex("rw_after_rw", S_RW, 0); ex("rw_after_cnt", S_CNT, 0);
    ex("rw_after_pcen", S_PCEN, 0); ex("rw_after_done", S_DONE, 0);
    tick();
    $display("test_reset_in_wait done");
  endtask

  task automatic test_saturate();
    do_reset();
    Start = 1'b1;
    Instruction = 9'h13C;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 15) ex("sat_c_cnt15", S_C_CNT, 4'hF);
      if (i == 16) ex("sat_c_cnt16", S_C_CNT, 4'hF);
      tick();
    end
    ex("sat_c_cnt20", S_C_CNT, 4'hF);
    ex("sat_main_cnt20", S_CNT, 20);
    tick();
    $display("test_saturate done");
  endtask

  initial begin
    Reset       = 1'b1;
    Start       = 1'b0;
    Instruction = 9'h000;
    ALU_Out     = 8'h00;
    RegOutA     = 8'h00;
    RegOutB     = 8'h5A;
    ProgCtr_p1  = 10'h045;
    mem_out     = 8'hA7;
    test_reset();
    test_immediate();
    test_ldw();
    test_branch();
    test_decode();
    test_done();
    test_reset_in_wait();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Sequenced control unit for the 9-bit accumulator ISA, for cores that need more than a purely combinational decoder.
- Decodes each instruction, drives ALU, register-file, memory and branch controls, and runs a run/stall/done state machine.
- Stalls the PC for a parametrised data-memory load latency, gates execution with a Start/Done handshake and keeps a retired-instruction counter.
- Sits between instruction ROM / PC and the datapath (ALU, reg file, data memory).

Parameters:
- W, 8: datapath width; immediates zero-extended to W.
- T, 10: program counter width.
- MEM_LAT, 1: data-memory read latency in cycles (0..15); 0 means the LDW result is valid in the issue cycle.
- LINK_REG, 14: register written by JAL.
- CNT_W, 16: retired-instruction counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  level request to begin or continue execution.
- Instruction  in  9  current instruction word.
- ALU_Out  in  W  ALU result.
- RegOutA  in  W  reg file port A data.
- RegOutB  in  W  reg file port B data.
- ProgCtr_p1  in  T  PC+1.
- mem_out  in  W  data memory read data.
- ALU_OP  out  op_mne  ALU operation.
- ALU_A  out  W  ALU operand A.
- ALU_B  out  W  ALU operand B.
- RaddrA  out  4  reg file read address A.
- RaddrB  out  4  reg file read address B.
- Waddr  out  4  reg file write address.
- RegInput  out  W  reg file write data.
- RegWrite  out  1  reg file write enable.
- write_mem  out  1  data memory write strobe.
- PC_en  out  1  PC may advance this cycle.
- BranchTaken  out  1  load PC from branch target this cycle; only with PC_en.
- Busy  out  1  state is RUN or MEM_WAIT.
- Done  out  1  registered; high in DONE.
- InstrCount  out  CNT_W  retired instructions, saturating.

Behaviour:
- States: IDLE, RUN, MEM_WAIT, DONE. Reset returns to IDLE regardless of state and has priority over Start. Reset also clears the wait counter and InstrCount, and drives Done=0.
- Defaults in every state and opcode unless overridden:
  - ALU_OP=NOP, ALU_A=RegOutA, ALU_B=RegOutB, RegInput=ALU_Out.
  - RaddrA=RaddrB=Waddr=0.
  - RegWrite=0, write_mem=0, PC_en=0, BranchTaken=0.
- IDLE: defaults only; Start=1 moves to RUN on the next edge.
- RUN: decode is combinational. PC_en=1 and RegWrite=1 unless an opcode overrides them.
  - Instruction[8]=1: ALU_A={0,Instruction[7:0]}, Waddr=0.
  - Otherwise opcode=Instruction[7:4], operand r=Instruction[3:0]:
    - 0 PUT: Waddr=r.
    - 1 GET: RaddrA=r.
    - 2 LDW: RaddrA=r, RegInput=mem_out. If MEM_LAT=0, completes this cycle. Else RegWrite=0, PC_en=0, wait counter loads MEM_LAT, go to MEM_WAIT.
    - 3 STW: RaddrA=r, RegWrite=0, write_mem=1 for exactly one cycle.
    - 4 NXT: RaddrA=Waddr=r. r in 8..10: SUB with ALU_B=1. r in 11..13: ADD with ALU_B=1. Otherwise NOP.
    - 5 CLB: ALU_OP=CLB, RaddrA=Waddr=r.
    - 6 ADD, 7 AND, A XOR: corresponding op, RaddrA=r.
    - 8 LSH: ALU_OP=LSH, ALU_A={0,Instruction[2:0]}.
    - 9 RXR: ALU_OP=RXOR, RaddrA=r.
    - B DNE: RegWrite=0, PC_en=0, go to DONE.
    - C JNZ, D JEZ, E JMP: RegWrite=0, RaddrA=r. BranchTaken = (RegOutA!=0), (RegOutA==0), 1 respectively.
    - F JAL: RaddrA=r, Waddr=LINK_REG, RegInput=ProgCtr_p1[W-1:0] (zero-extended if T<W), BranchTaken=1.
- MEM_WAIT: RaddrA and RegInput held from the latched LDW operand. The counter decrements each cycle.
  - When the counter reaches 1: RegWrite=1, Waddr=0, PC_en=1, next state RUN.
  - Otherwise all write and PC strobes stay 0.
  - Instruction must stay stable in this state because PC is frozen.
- Retire: InstrCount increments on each edge where PC_en=1 (including a completed LDW) and on DNE. It saturates at all-ones.
- DONE: Done=1, defaults otherwise. Start=0 moves to IDLE, which clears Done the cycle after. Start held high keeps the block in DONE.
- Start changes in RUN or MEM_WAIT have no effect.

Test Plan:
- Reset, Start=1, Instruction=9'h1_3C: cycle after Start, ALU_A=8'h3C, Waddr=0, RegWrite=1, PC_en=1; InstrCount=1 next edge.
- MEM_LAT=3, LDW r5 (9'h025), mem_out=8'hA7: RegWrite=0/PC_en=0 for issue+2 cycles, third cycle RegWrite=1, RegInput=8'hA7, Waddr=0, PC_en=1; MEM_LAT=0 build completes in one cycle.
- JNZ r2 with RegOutA=0 -> BranchTaken=0, PC_en=1; RegOutA=8'h01 -> BranchTaken=1. JAL r3 with ProgCtr_p1=10'h045 -> Waddr=14, RegInput=8'h45, RegWrite=1.
- NXT r9 -> ALU_OP=SUB, ALU_B=1, Waddr=9; NXT r12 -> ADD; NXT r4 -> NOP.
- DNE -> Done=1 next cycle, Busy=0; keep Start=1 -> stays DONE; Start=0 -> IDLE, Done=0 one cycle later.
- Reset asserted together with Start in the second MEM_WAIT cycle -> IDLE next edge, RegWrite=0, InstrCount=0. CNT_W=4 with 20 retirements -> InstrCount=4'hF.
